hu_audioenc_dma_rd_arb: RTL and testbench

// - Shares the accelerator's single 64-bit DMA read port (ctrl + chnl) between two requesters:
//   req0 = audio-frame loader, req1 = coefficient/config-table loader.
// - Grants one request at a time, forwards its ctrl message, then steers read-chnl beats to

---
 rtl/hu_audioenc_dma_pkg.sv | 47 ++++
 rtl/hu_audioenc_dma_rd_arb.sv | 138 +++++++++++++
 tb/tb_hu_audioenc_dma_rd_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hu_audioenc_dma_pkg.sv
// Shared types and helpers for the audio-encoder DMA read arbiter.
// Holds the ctrl message layout, transfer-size encodings, the arbiter state
// enum and the beat-count calculation used when a burst is launched.
package hu_audioenc_dma_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned IDX_W  = 32;
   localparam int unsigned LEN_W  = 32;
   localparam int unsigned SIZE_W = 3;
   localparam int unsigned MSG_W  = SIZE_W + LEN_W + IDX_W;

   // Transfer-size encodings (element = 2^size bytes)
   localparam logic [SIZE_W-1:0] SZ_BYTE  = 3'd0;
   localparam logic [SIZE_W-1:0] SZ_HWORD = 3'd1;
   localparam logic [SIZE_W-1:0] SZ_WORD  = 3'd2;
   localparam logic [SIZE_W-1:0] SZ_DWORD = 3'd3;

   // ctrl message, packed {size, length, index}
   typedef struct packed {
      logic [SIZE_W-1:0] size;
      logic [LEN_W-1:0]  length;
      logic [IDX_W-1:0]  index;
   } dma_ctrl_msg_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CTRL = 2'd1,
      ST_DATA = 2'd2
   } dma_rd_state_e;

   // 64-bit beats needed for len elements: ceil(len * 2^size / 8).
   // Reserved size codes (>3) behave as a doubleword.
   function automatic logic [LEN_W-1:0] dma_beats(input logic [SIZE_W-1:0] size,
                                                  input logic [LEN_W-1:0]  len);
      logic [LEN_W+2:0] bytes;
      case (size)
         SZ_BYTE:  bytes = {3'b000, len};
         SZ_HWORD: bytes = {2'b00, len, 1'b0};
         SZ_WORD:  bytes = {1'b0, len, 2'b00};
         SZ_DWORD: bytes = {len, 3'b000};
         default:  bytes = {len, 3'b000};
      endcase
      bytes = bytes + (LEN_W+3)'(7);
      return bytes[LEN_W+2:3];
   endfunction

endpackage

// File: rtl/hu_audioenc_dma_rd_arb.sv
// Two-way round-robin arbiter sharing one 64-bit DMA read port.
// req0 = audio-frame loader, req1 = coefficient/config-table loader.
// Ports:
//   clk, rst               clock, async active-high reset
//   reqN_ctrl_*            read-request handshake from requester N (msg {size,length,index})
//   reqN_chnl_*            read-data beats steered to requester N
//   dma_read_ctrl_*        request forwarded to the ESP DMA
//   dma_read_chnl_*        read-data beats from the ESP DMA
//   busy                   arbiter is serving a burst (state != IDLE)
//   grant_id               currently/last granted requester
module hu_audioenc_dma_rd_arb
   import hu_audioenc_dma_pkg::*;
(
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_ctrl_val,
   output logic              req0_ctrl_rdy,
   input  logic [MSG_W-1:0]  req0_ctrl_msg,
   output logic              req0_chnl_val,
   input  logic              req0_chnl_rdy,
   output logic [DATA_W-1:0] req0_chnl_msg,

   input  logic              req1_ctrl_val,
   output logic              req1_ctrl_rdy,
   input  logic [MSG_W-1:0]  req1_ctrl_msg,
   output logic              req1_chnl_val,
   input  logic              req1_chnl_rdy,
   output logic [DATA_W-1:0] req1_chnl_msg,

   output logic              dma_read_ctrl_val,
   input  logic              dma_read_ctrl_rdy,
   output logic [MSG_W-1:0]  dma_read_ctrl_msg,
   input  logic              dma_read_chnl_val,
   output logic              dma_read_chnl_rdy,
   input  logic [DATA_W-1:0] dma_read_chnl_msg,

   output logic              busy,
   output logic              grant_id
);

   dma_rd_state_e    state_q, state_d;
   logic             grant_q, grant_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

   dma_ctrl_msg_t    sel_msg;
   logic [LEN_W-1:0] burst_beats;
   logic             sel_chnl_rdy;

   // Granted requester's request and beat-ready
   assign sel_msg      = grant_q ? dma_ctrl_msg_t'(req1_ctrl_msg) : dma_ctrl_msg_t'(req0_ctrl_msg);
   assign burst_beats  = dma_beats(sel_msg.size, sel_msg.length);
   assign sel_chnl_rdy = grant_q ? req1_chnl_rdy : req0_chnl_rdy;

   // Beat data is fanned out; only the granted requester sees chnl_val
   assign req0_chnl_msg = dma_read_chnl_msg;
   assign req1_chnl_msg = dma_read_chnl_msg;

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;

   // Next-state and handshake steering
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      rr_ptr_d          = rr_ptr_q;
      beat_cnt_d        = beat_cnt_q;
      req0_ctrl_rdy     = 1'b0;
      req1_ctrl_rdy     = 1'b0;
      req0_chnl_val     = 1'b0;
      req1_chnl_val     = 1'b0;
      dma_read_ctrl_val = 1'b0;
      dma_read_ctrl_msg = '0;
      dma_read_chnl_rdy = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Grant is registered here so no val->DMA combinational path exists
            if (req0_ctrl_val || req1_ctrl_val) begin
               grant_d = (req0_ctrl_val && req1_ctrl_val) ? rr_ptr_q : req1_ctrl_val;
               state_d = ST_CTRL;
            end
         end

         ST_CTRL: begin
            dma_read_ctrl_val = 1'b1;
            dma_read_ctrl_msg = sel_msg;
            req0_ctrl_rdy     = !grant_q && dma_read_ctrl_rdy;
            req1_ctrl_rdy     =  grant_q && dma_read_ctrl_rdy;
            if (dma_read_ctrl_rdy) begin
               beat_cnt_d = burst_beats;
               if (burst_beats == '0) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = ~grant_q;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            req0_chnl_val     = !grant_q && dma_read_chnl_val;
            req1_chnl_val     =  grant_q && dma_read_chnl_val;
            dma_read_chnl_rdy = sel_chnl_rdy;
            if (dma_read_chnl_val && sel_chnl_rdy) begin
               beat_cnt_d = beat_cnt_q - LEN_W'(1);
               if (beat_cnt_q == LEN_W'(1)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = ~grant_q;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         rr_ptr_q   <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // The granted requester must hold its request until it is accepted
   a_ctrl_val_held: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_CTRL) |-> (grant_q ? req1_ctrl_val : req0_ctrl_val));

endmodule

// File: tb/tb_hu_audioenc_dma_rd_arb.sv
// Randomized bench for hu_audioenc_dma_rd_arb against a transaction-level model:
// request queues per requester, round-robin preference, and an outstanding-beat count.
module tb_hu_audioenc_dma_rd_arb;
   import hu_audioenc_dma_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_ctrl_val, req0_ctrl_rdy, req0_chnl_val, req0_chnl_rdy;
   logic              req1_ctrl_val, req1_ctrl_rdy, req1_chnl_val, req1_chnl_rdy;
   logic [MSG_W-1:0]  req0_ctrl_msg, req1_ctrl_msg, dma_read_ctrl_msg;
   logic [DATA_W-1:0] req0_chnl_msg, req1_chnl_msg, dma_read_chnl_msg;
   logic              dma_read_ctrl_val, dma_read_ctrl_rdy;
   logic              dma_read_chnl_val, dma_read_chnl_rdy;
   logic              busy, grant_id;

   always #5 clk = ~clk;

   hu_audioenc_dma_rd_arb dut (
      .clk               (clk),
      .rst               (rst),
      .req0_ctrl_val     (req0_ctrl_val),
      .req0_ctrl_rdy     (req0_ctrl_rdy),
      .req0_ctrl_msg     (req0_ctrl_msg),
      .req0_chnl_val     (req0_chnl_val),
      .req0_chnl_rdy     (req0_chnl_rdy),
      .req0_chnl_msg     (req0_chnl_msg),
      .req1_ctrl_val     (req1_ctrl_val),
      .req1_ctrl_rdy     (req1_ctrl_rdy),
      .req1_ctrl_msg     (req1_ctrl_msg),
      .req1_chnl_val     (req1_chnl_val),
      .req1_chnl_rdy     (req1_chnl_rdy),
      .req1_chnl_msg     (req1_chnl_msg),
      .dma_read_ctrl_val (dma_read_ctrl_val),
      .dma_read_ctrl_rdy (dma_read_ctrl_rdy),
      .dma_read_ctrl_msg (dma_read_ctrl_msg),
      .dma_read_chnl_val (dma_read_chnl_val),
      .dma_read_chnl_rdy (dma_read_chnl_rdy),
      .dma_read_chnl_msg (dma_read_chnl_msg),
      .busy              (busy),
      .grant_id          (grant_id)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [MSG_W-1:0] q0[$];
   logic [MSG_W-1:0] q1[$];
   bit      m_busy, m_ctrl_done, m_grant, m_pref;
   longint  m_rem;
   int      rx_cnt[2];
   int      grant_log[$];

   // stimulus knobs (percent probabilities)
   int p_arr, p_dctrl, p_dval, p_rdy0, p_rdy1;
   bit toggle1;

   function automatic bit rnd(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   function automatic logic [MSG_W-1:0] mk(input int sz, input longint len, input logic [31:0] idx);
      logic [MSG_W-1:0] m;
      m = {3'(sz), 32'(len), idx};
      return m;
   endfunction

   // Beats from first principles: bytes requested, rounded up to 8-byte beats
   function automatic longint ref_beats(input logic [MSG_W-1:0] m);
      longint sz, len, bytes;
      sz  = longint'(m[MSG_W-1 -: 3]);
      len = longint'(m[IDX_W +: LEN_W]);
      if (sz > 3) sz = 3;
      bytes = len * (64'sd1 << sz);
      return (bytes + 7) / 8;
   endfunction

   function automatic logic [MSG_W-1:0] head(input bit g);
      if (g) return q1[0];
      return q0[0];
   endfunction

   task automatic model_clear();
      q0.delete(); q1.delete();
      m_busy = 0; m_ctrl_done = 0; m_grant = 0; m_pref = 0; m_rem = 0;
   endtask

   task automatic drive();
      if (p_arr > 0 && rnd(p_arr)) begin
         logic [MSG_W-1:0] m;
         m = mk($urandom_range(0, 7), rnd(15) ? 0 : $urandom_range(1, 12), $urandom);
         if ($urandom_range(0, 1) == 0) begin
            if (q0.size() < 3) q0.push_back(m);
         end else begin
            if (q1.size() < 3) q1.push_back(m);
         end
      end
      req0_ctrl_val     = (q0.size() > 0);
      req0_ctrl_msg     = (q0.size() > 0) ? q0[0] : '0;
      req1_ctrl_val     = (q1.size() > 0);
      req1_ctrl_msg     = (q1.size() > 0) ? q1[0] : '0;
      dma_read_ctrl_rdy = rnd(p_dctrl);
      dma_read_chnl_val = rnd(p_dval);
      dma_read_chnl_msg = {$urandom, $urandom};
      req0_chnl_rdy     = rnd(p_rdy0);
      req1_chnl_rdy     = toggle1 ? ~req1_chnl_rdy : rnd(p_rdy1);
   endtask

   task automatic end_burst();
      m_busy = 0;
      m_pref = ~m_grant;
   endtask

   // Compare outputs against model expectations, then advance the model by one cycle
   task automatic check_and_update();
      bit ctrl_ph, data_ph, sel_rdy;
      ctrl_ph = m_busy && !m_ctrl_done;
      data_ph = m_busy && m_ctrl_done;
      sel_rdy = m_grant ? req1_chnl_rdy : req0_chnl_rdy;

      chk("busy", 128'(busy), 128'(m_busy));
      if (m_busy) chk("grant_id", 128'(grant_id), 128'(m_grant));
      chk("dma_ctrl_val", 128'(dma_read_ctrl_val), 128'(ctrl_ph));
      if (ctrl_ph) chk("dma_ctrl_msg", 128'(dma_read_ctrl_msg), 128'(head(m_grant)));
      chk("req0_ctrl_rdy", 128'(req0_ctrl_rdy), 128'(ctrl_ph && !m_grant && dma_read_ctrl_rdy));
      chk("req1_ctrl_rdy", 128'(req1_ctrl_rdy), 128'(ctrl_ph && m_grant && dma_read_ctrl_rdy));
      chk("req0_chnl_val", 128'(req0_chnl_val), 128'(data_ph && !m_grant && dma_read_chnl_val));
      chk("req1_chnl_val", 128'(req1_chnl_val), 128'(data_ph && m_grant && dma_read_chnl_val));
      chk("dma_chnl_rdy", 128'(dma_read_chnl_rdy), 128'(data_ph && sel_rdy));

      if (!m_busy) begin
         if (q0.size() > 0 || q1.size() > 0) begin
            m_grant = (q0.size() > 0 && q1.size() > 0) ? m_pref : (q1.size() > 0);
            m_busy = 1;
            m_ctrl_done = 0;
            grant_log.push_back(int'(m_grant));
         end
      end else if (ctrl_ph) begin
         if (dma_read_ctrl_rdy) begin
            longint b;
            b = ref_beats(head(m_grant));
            if (m_grant) void'(q1.pop_front()); else void'(q0.pop_front());
            if (b == 0) end_burst();
            else begin
               m_rem = b;
               m_ctrl_done = 1;
            end
         end
      end else if (dma_read_chnl_val && sel_rdy) begin
         chk("beat_data", 128'(m_grant ? req1_chnl_msg : req0_chnl_msg), 128'(dma_read_chnl_msg));
         rx_cnt[m_grant]++;
         m_rem--;
         if (m_rem == 0) end_burst();
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      check_and_update();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle(input int max_cyc, output int used);
      used = 0;
      while ((m_busy || q0.size() > 0 || q1.size() > 0) && used < max_cyc) begin
         cycle();
         used++;
      end
      chk("drain_done", 128'(m_busy || q0.size() > 0 || q1.size() > 0), 128'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},     128'(busy), 128'(0));
      chk({tag, "_grant"},    128'(grant_id), 128'(0));
      chk({tag, "_dctrlval"}, 128'(dma_read_ctrl_val), 128'(0));
      chk({tag, "_dchnlrdy"}, 128'(dma_read_chnl_rdy), 128'(0));
      chk({tag, "_c0rdy"},    128'(req0_ctrl_rdy), 128'(0));
      chk({tag, "_c1rdy"},    128'(req1_ctrl_rdy), 128'(0));
      chk({tag, "_ch0val"},   128'(req0_chnl_val), 128'(0));
      chk({tag, "_ch1val"},   128'(req1_chnl_val), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int used;
      rst = 1'b1;
      model_clear();
      rx_cnt[0] = 0; rx_cnt[1] = 0;
      p_arr = 0; p_dctrl = 100; p_dval = 100; p_rdy0 = 100; p_rdy1 = 100; toggle1 = 0;
      req1_chnl_rdy = 1'b0;

      // Reset with both requesters already pending and DMA inputs active
      q0.push_back(mk(3, 2, 32'h10)); q0.push_back(mk(0, 9, 32'h11));
      q1.push_back(mk(1, 5, 32'h20)); q1.push_back(mk(2, 3, 32'h21));
      drive();
      #2;
      check_reset_outputs("rst");
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention: req0 wins first, then alternation
      run_until_idle(300, used);
      chk("contend_n", 128'(grant_log.size()), 128'(4));
      if (grant_log.size() >= 3) begin
         chk("contend_g0", 128'(grant_log[0]), 128'(0));
         chk("contend_g1", 128'(grant_log[1]), 128'(1));
         chk("contend_g2", 128'(grant_log[2]), 128'(0));
      end

      // Single request: 7 words of 4 bytes -> 4 beats
      rx_cnt[0] = 0; rx_cnt[1] = 0;
      q0.push_back(mk(2, 7, 32'h100));
      run_until_idle(100, used);
      chk("single_beats0", 128'(rx_cnt[0]), 128'(4));
      chk("single_beats1", 128'(rx_cnt[1]), 128'(0));

      // Backpressure: req1 ready toggles, DMA valid held
      rx_cnt[0] = 0; rx_cnt[1] = 0;
      toggle1 = 1;
      q1.push_back(mk(3, 16, 32'h200));
      run_until_idle(200, used);
      toggle1 = 0;
      chk("bp_beats1", 128'(rx_cnt[1]), 128'(16));

      // Zero length: one grant cycle, one ctrl cycle, then idle
      rx_cnt[1] = 0;
      q1.push_back(mk(3, 0, 32'h300));
      run_until_idle(20, used);
      chk("zero_cycles", 128'(used), 128'(2));
      chk("zero_beats", 128'(rx_cnt[1]), 128'(0));

      // Randomized traffic including stray DMA beats outside DATA
      p_arr = 30; p_dctrl = 60; p_dval = 60; p_rdy0 = 70; p_rdy1 = 70;
      for (int i = 0; i < 1500; i++) cycle();
      p_arr = 0;
      run_until_idle(2000, used);

      // Reset in the middle of a burst with 5 beats outstanding
      p_dctrl = 100; p_dval = 100; p_rdy0 = 100; p_rdy1 = 100;
      q0.push_back(mk(3, 10, 32'h400));
      used = 0;
      while (!(m_busy && m_ctrl_done && m_rem == 5) && used < 50) begin
         cycle();
         used++;
      end
      chk("mid_rem", 128'(m_rem), 128'(5));
      drive();
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_clear();
      @(posedge clk); #1;
      chk("midrst_edge_busy", 128'(busy), 128'(0));
      rst = 1'b0;

      // After reset the preference is back to req0
      grant_log.delete();
      q1.push_back(mk(2, 4, 32'h500));
      q0.push_back(mk(2, 4, 32'h501));
      run_until_idle(100, used);
      chk("post_rst_n", 128'(grant_log.size()), 128'(2));
      if (grant_log.size() >= 2) begin
         chk("post_rst_g0", 128'(grant_log[0]), 128'(0));
         chk("post_rst_g1", 128'(grant_log[1]), 128'(1));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
